timing_pattern_gen: RTL and testbench

TIMING_PATTERN_GEN -- requirements
Module: timing_pattern_gen

---
 rtl/timing_gen_pkg.sv | 20 ++
 rtl/strobe_phase_cnt.sv | 47 ++++
 rtl/timing_pattern_gen.sv | 157 +++++++++++++++
 tb/tb_timing_pattern_gen.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/timing_gen_pkg.sv
// Shared constants, FSM state type and width helper for the timing pattern generator.
package timing_gen_pkg;

  localparam int DEF_PERIOD_TICKS = 10;
  localparam int DEF_HALF_TICKS   = DEF_PERIOD_TICKS / 2;
  localparam int DEF_SETUP_TICKS  = 2;
  localparam int DEF_HOLD_TICKS   = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    LAUNCH = 2'd2
  } state_e;

  // Width of a tick index within one period; never narrower than one bit.
  function automatic int ow_width(input int period);
    return (period > 1) ? $clog2(period) : 1;
  endfunction

endpackage

// File: rtl/strobe_phase_cnt.sv
// Free-running tick counter with the registered sample strobe and a period-end flag.
module strobe_phase_cnt
  import timing_gen_pkg::*;
#(
  parameter int  PERIOD_TICKS = DEF_PERIOD_TICKS,
  parameter int  HALF_TICKS   = PERIOD_TICKS / 2,
  localparam int CW           = ow_width(PERIOD_TICKS)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  output logic [CW-1:0] cnt_o,
  output logic          strobe_o,
  output logic          period_end_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          strobe_q;
  logic          strobe_d;

  assign period_end_o = (cnt_q == CW'(PERIOD_TICKS - 1));
  assign cnt_o        = cnt_q;
  assign strobe_o     = strobe_q;

  // Strobe is computed from the next count so it stays aligned with cnt every cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (period_end_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    strobe_d = (32'(cnt_d) < 32'(HALF_TICKS));
  end

  // Reset parks the counter on the last tick so the first edge lands on tick 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= CW'(PERIOD_TICKS - 1);
      strobe_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
    end
  end

endmodule

// File: rtl/timing_pattern_gen.sv
// Launches a captured data value at a chosen tick of a future strobe period and
// flags setup/hold violations of that launch against the strobe rise.
module timing_pattern_gen
  import timing_gen_pkg::*;
#(
  parameter int  PERIOD_TICKS = DEF_PERIOD_TICKS,
  parameter int  HALF_TICKS   = PERIOD_TICKS / 2,
  parameter int  SETUP_TICKS  = DEF_SETUP_TICKS,
  parameter int  HOLD_TICKS   = DEF_HOLD_TICKS,
  parameter int  DW           = 2,
  localparam int OW           = ow_width(PERIOD_TICKS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [DW-1:0] cfg_data,
  input  logic [OW-1:0] cfg_offset,
  output logic          strobe,
  output logic [DW-1:0] dout,
  output logic          done,
  output logic          viol_setup,
  output logic          viol_hold,
  output logic          cfg_err
);

  state_e        state_q, state_d;
  logic [DW-1:0] data_q, data_d;
  logic [OW-1:0] off_q, off_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          done_q, done_d;
  logic          vs_q, vs_d;
  logic          vh_q, vh_d;
  logic          err_q, err_d;
  logic          ready_q, ready_d;

  logic [OW-1:0] cnt_s;
  logic          period_end_s;
  logic          hs_s;
  logic          bad_off_s;
  logic          load_s;
  logic          changed_s;
  logic          setup_short_s;
  logic          hold_short_s;

  strobe_phase_cnt #(
    .PERIOD_TICKS(PERIOD_TICKS),
    .HALF_TICKS  (HALF_TICKS)
  ) u_phase (
    .clk_i       (clk),
    .rst_i       (rst),
    .cnt_o       (cnt_s),
    .strobe_o    (strobe),
    .period_end_o(period_end_s)
  );

  assign hs_s          = cfg_valid && ready_q;
  assign bad_off_s     = (int'(cfg_offset) >= PERIOD_TICKS);
  assign changed_s     = (data_q != dout_q);
  assign setup_short_s = ((PERIOD_TICKS - int'(off_q)) < SETUP_TICKS);
  assign hold_short_s  = (int'(off_q) < HOLD_TICKS);

  // Next-state and output computation; a load is registered one cycle before it is visible.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    off_d   = off_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    vs_d    = 1'b0;
    vh_d    = 1'b0;
    err_d   = 1'b0;
    load_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (hs_s) begin
          data_d = cfg_data;
          off_d  = cfg_offset;
          if (bad_off_s) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = ARM;
          end
        end else begin
          state_d = IDLE;
        end
      end
      // Any period end seen here is at least one cycle after the handshake,
      // so the following tick 0 is far enough out to be the launch period.
      ARM: begin
        if (period_end_s) begin
          if (off_q == OW'(0)) begin
            load_s = 1'b1;
          end else begin
            state_d = LAUNCH;
          end
        end else begin
          state_d = ARM;
        end
      end
      LAUNCH: begin
        if (cnt_s == (off_q - OW'(1))) begin
          load_s = 1'b1;
        end else begin
          state_d = LAUNCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (load_s) begin
      dout_d  = data_q;
      done_d  = 1'b1;
      vs_d    = changed_s && setup_short_s;
      vh_d    = changed_s && hold_short_s;
      state_d = IDLE;
    end else begin
      dout_d  = dout_q;
    end
    ready_d = (state_d == IDLE);
  end

  // State and output registers; ready stays low while reset is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      off_q   <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      vs_q    <= 1'b0;
      vh_q    <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      off_q   <= off_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      vs_q    <= vs_d;
      vh_q    <= vh_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end

  assign cfg_ready  = ready_q;
  assign dout       = dout_q;
  assign done       = done_q;
  assign viol_setup = vs_q;
  assign viol_hold  = vh_q;
  assign cfg_err    = err_q;

endmodule

// File: tb/tb_timing_pattern_gen.sv
// Scoreboard bench: the driver predicts each launch from period arithmetic and
// queues it; a negedge monitor compares every cycle against the queue.
module tb_timing_pattern_gen;

  localparam int P     = 10;
  localparam int HALF  = 5;
  localparam int SETUP = 2;
  localparam int HOLD  = 1;

  typedef struct {
    int         cyc;
    logic [1:0] dout;
    bit         done;
    bit         vs;
    bit         vh;
    bit         err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [1:0] cfg_data = 2'b00;
  logic [3:0] cfg_offset = 4'd0;
  logic       strobe;
  logic [1:0] dout;
  logic       done, viol_setup, viol_hold, cfg_err;

  exp_t       exp_q[$];
  bit         exp_ready[int];
  int         cyc = -1;
  int         busy_until = 0;
  logic [1:0] drv_dout = 2'b00;
  logic [1:0] mon_dout = 2'b00;
  bit         mon_en = 1'b0;
  int         n_cmp = 0;
  int         n_fail = 0;

  timing_pattern_gen dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_data  (cfg_data),
    .cfg_offset(cfg_offset),
    .strobe    (strobe),
    .dout      (dout),
    .done      (done),
    .viol_setup(viol_setup),
    .viol_hold (viol_hold),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  // Reference: launch lands in the first period whose tick 0 is >= 2 cycles out.
  task automatic model_push(input logic [1:0] d, input logic [3:0] o);
    exp_t e;
    int   c, dd, t0;
    bit   chg;
    if (int'(o) >= P) begin
      e.cyc = cyc + 1; e.dout = drv_dout;
      e.done = 1'b0; e.vs = 1'b0; e.vh = 1'b0; e.err = 1'b1;
      busy_until = cyc + 1;
    end else begin
      c  = cyc % P;
      dd = P - c;
      t0 = cyc + dd + ((dd < 2) ? P : 0);
      chg = (d != drv_dout);
      e.cyc = t0 + int'(o); e.dout = d;
      e.done = 1'b1; e.err = 1'b0;
      e.vs = chg && ((P - int'(o)) < SETUP);
      e.vh = chg && (int'(o) < HOLD);
      busy_until = e.cyc;
      drv_dout = d;
    end
    exp_q.push_back(e);
  endtask

  task automatic drive_cycle(input bit want, input logic [1:0] d, input logic [3:0] o,
                             input int want_cnt, output bit took);
    @(posedge clk);
    #1;
    cyc++;
    took = 1'b0;
    exp_ready[cyc] = (cyc >= busy_until);
    if (want && exp_ready[cyc] && (want_cnt < 0 || (cyc % P) == want_cnt)) begin
      cfg_valid = 1'b1; cfg_data = d; cfg_offset = o;
      model_push(d, o);
      took = 1'b1;
    end else if (!exp_ready[cyc]) begin
      cfg_valid = 1'($urandom); cfg_data = 2'($urandom); cfg_offset = 4'($urandom);
    end else begin
      cfg_valid = 1'b0; cfg_data = 2'($urandom); cfg_offset = 4'($urandom);
    end
  endtask

  task automatic idle_cycles(input int n);
    bit t;
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 2'b00, 4'd0, -1, t);
  endtask

  // d < 0 requests the value currently on dout.
  task automatic launch(input int d, input int o, input int want_cnt);
    bit         took = 1'b0;
    logic [1:0] dv;
    for (int i = 0; i < 100 && !took; i++) begin
      dv = (d < 0) ? drv_dout : 2'(d);
      drive_cycle(1'b1, dv, 4'(o), want_cnt, took);
    end
    n_cmp++;
    if (!took) begin
      n_fail++;
      $display("FAIL launch_timeout got no handshake want handshake (data %0d offset %0d)", d, o);
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    logic [7:0] got;
    got = {strobe, cfg_ready, done, viol_setup, viol_hold, cfg_err, dout};
    n_cmp++;
    if (got !== 8'h00) begin
      n_fail++;
      $display("FAIL %s got %b want %b", nm, got, 8'h00);
    end
  endtask

  // Monitor: every cycle compare strobe/ready/pulses/dout with the scoreboard.
  logic [7:0] m_got, m_want;
  exp_t       m_e;
  always @(negedge clk) begin
    if (mon_en && !rst && cyc >= 0) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        m_e = exp_q.pop_front();
        n_cmp++; n_fail++;
        $display("FAIL missed_event got none want event at cycle %0d", m_e.cyc);
      end
      m_got = {strobe, cfg_ready, done, viol_setup, viol_hold, cfg_err, dout};
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        m_e = exp_q.pop_front();
        mon_dout = m_e.dout;
        m_want = {((cyc % P) < HALF), exp_ready[cyc], m_e.done, m_e.vs, m_e.vh, m_e.err, m_e.dout};
      end else begin
        m_want = {((cyc % P) < HALF), exp_ready[cyc], 4'b0000, mon_dout};
      end
      n_cmp++;
      if (m_got !== m_want) begin
        n_fail++;
        $display("FAIL cycle%0d {strobe,ready,done,vs,vh,err,dout} got %b want %b", cyc, m_got, m_want);
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_hold");
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;

    idle_cycles(22);
    launch(3, 5, 3);
    launch(1, 9, -1);
    launch(2, 0, 0);
    launch(3, 0, 8);
    launch(0, 12, -1);
    idle_cycles(2);
    launch(-1, 9, -1);
    launch(1, 0, 9);

    for (int k = 0; k < 40; k++) begin
      idle_cycles($urandom_range(0, 3));
      launch(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
             ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, P - 1)));
    end

    idle_cycles(1);
    launch(3, 5, 3);
    idle_cycles(2);
    #2;
    mon_en = 1'b0;
    rst = 1'b1;
    cfg_valid = 1'b0;
    #1;
    check_reset_outputs("async_reset_in_arm");
    exp_q.delete();
    exp_ready.delete();
    busy_until = 0;
    drv_dout = 2'b00;
    mon_dout = 2'b00;
    cyc = -1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_hold_after_abort");
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    idle_cycles(15);
    for (int k = 0; k < 8; k++) begin
      launch(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), -1);
    end

    for (int i = 0; i < 40 && exp_q.size() > 0; i++) idle_cycles(1);
    idle_cycles(2);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending want 0 pending", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
